apuf_eval_ctrl: RTL and testbench

Sequencer for a bank of NUM_PUF arbiter-PUF chains built from LUT switch stages, used for an XOR-PUF. It accepts a challenge over a valid/ready handshake and holds it on the switch select lines. It then fires the race trigger REPEAT times and samples the arbiter outputs after each firing. Each chain's samples are majority-voted, and the voted bits and their XOR are returned over a valid/ready handshake.

---
 rtl/apuf_eval_ctrl.sv | 168 ++++++++++++++++
 tb/tb_apuf_eval_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apuf_eval_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apuf_eval_ctrl : arbiter XOR-PUF sequencer (challenge, repeated fire, vote)
// Rev 1.0
// ----------------------------------------------------------------------------
module apuf_eval_ctrl #(
  parameter int CHAL_W     = 64,
  parameter int NUM_PUF    = 4,
  parameter int SETUP_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int REPEAT     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CHAL_W-1:0]  chal_in,
  input  logic               chal_valid,
  output logic               chal_ready,
  output logic [CHAL_W-1:0]  puf_chal,
  output logic               puf_trig,
  input  logic [NUM_PUF-1:0] puf_resp,
  output logic [NUM_PUF-1:0] resp_bits,
  output logic               resp_out,
  output logic [NUM_PUF-1:0] resp_unstable,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               busy
);

  localparam int C_TMAX = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
  localparam int C_TW   = $clog2(C_TMAX + 1);
  localparam int C_CW   = $clog2(REPEAT + 1);

  localparam logic [C_CW-1:0] C_REP       = C_CW'(REPEAT);
  localparam logic [C_CW-1:0] C_HALF      = C_CW'(REPEAT / 2);
  localparam logic [C_TW-1:0] C_SETUP_LD  = C_TW'(SETUP_CYC - 1);
  localparam logic [C_TW-1:0] C_SETTLE_LD = C_TW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_FIRE    = 3'd2,
    S_SAMPLE  = 3'd3,
    S_RECOVER = 3'd4,
    S_FINAL   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             state_q;
  logic [CHAL_W-1:0]  chal_q;
  logic               trig_q;
  logic [C_TW-1:0]    timer_q;
  logic [C_CW-1:0]    rep_q;
  logic [C_CW-1:0]    vote_q [NUM_PUF];
  logic [NUM_PUF-1:0] sync1_q;
  logic [NUM_PUF-1:0] sync2_q;
  logic [NUM_PUF-1:0] bits_q;
  logic               out_q;
  logic [NUM_PUF-1:0] unst_q;
  logic               valid_q;
  logic [NUM_PUF-1:0] voted_d;
  logic [NUM_PUF-1:0] unstable_d;

  // Arbiter latches settle asynchronously; only the second flop feeds the votes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= puf_resp;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    voted_d    = '0;
    unstable_d = '0;
    for (int i = 0; i < NUM_PUF; i++) begin
      voted_d[i]    = (vote_q[i] > C_HALF);
      unstable_d[i] = (vote_q[i] != '0) && (vote_q[i] != C_REP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      chal_q  <= '0;
      trig_q  <= 1'b0;
      timer_q <= '0;
      rep_q   <= '0;
      bits_q  <= '0;
      out_q   <= 1'b0;
      unst_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_PUF; i++) vote_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (chal_valid) begin
            chal_q  <= chal_in;
            rep_q   <= '0;
            timer_q <= C_SETUP_LD;
            state_q <= S_SETUP;
            for (int i = 0; i < NUM_PUF; i++) vote_q[i] <= '0;
          end
        end
        S_SETUP: begin
          if (timer_q == '0) begin
            timer_q <= C_SETTLE_LD;
            trig_q  <= 1'b1;
            state_q <= S_FIRE;
          end else begin
            timer_q <= timer_q - C_TW'(1);
          end
        end
        S_FIRE: begin
          if (timer_q == '0) state_q <= S_SAMPLE;
          else               timer_q <= timer_q - C_TW'(1);
        end
        // Trigger is still high here, so the race has had SETTLE_CYC+1 cycles.
        S_SAMPLE: begin
          for (int i = 0; i < NUM_PUF; i++) vote_q[i] <= vote_q[i] + C_CW'(sync2_q[i]);
          rep_q   <= rep_q + C_CW'(1);
          timer_q <= C_SETUP_LD;
          trig_q  <= 1'b0;
          state_q <= S_RECOVER;
        end
        S_RECOVER: begin
          if (timer_q == '0) begin
            if (rep_q == C_REP) begin
              state_q <= S_FINAL;
            end else begin
              timer_q <= C_SETTLE_LD;
              trig_q  <= 1'b1;
              state_q <= S_FIRE;
            end
          end else begin
            timer_q <= timer_q - C_TW'(1);
          end
        end
        S_FINAL: begin
          bits_q  <= voted_d;
          out_q   <= ^voted_d;
          unst_q  <= unstable_d;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign chal_ready    = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign puf_chal      = chal_q;
  assign puf_trig      = trig_q;
  assign resp_bits     = bits_q;
  assign resp_out      = out_q;
  assign resp_unstable = unst_q;
  assign resp_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_apuf_eval_ctrl.sv
`default_nettype none
// tb_apuf_eval_ctrl : scoreboard bench driving a default instance and a minimal-parameter instance.
module tb_apuf_eval_ctrl;

  localparam int CW = 64, NP = 4, SU = 4, ST = 8, RP = 5;
  localparam int B_CW = 16, B_SU = 1, B_ST = 3, B_RP = 1;

  typedef struct packed {
    logic [NP-1:0] bits;
    logic          out;
    logic [NP-1:0] unst;
  } resp_t;

  resp_t sb_a[$];
  resp_t sb_b[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [CW-1:0] a_chal_in = '0;
  logic          a_chal_valid = 1'b0;
  logic [NP-1:0] a_puf_resp = '0;
  logic          a_resp_ready = 1'b0;
  logic          a_chal_ready, a_puf_trig, a_resp_out, a_resp_valid, a_busy;
  logic [CW-1:0] a_puf_chal;
  logic [NP-1:0] a_resp_bits, a_resp_unstable;

  logic [B_CW-1:0] b_chal_in = '0;
  logic            b_chal_valid = 1'b0;
  logic [NP-1:0]   b_puf_resp = '0;
  logic            b_resp_ready = 1'b1;
  logic            b_chal_ready, b_puf_trig, b_resp_out, b_resp_valid, b_busy;
  logic [B_CW-1:0] b_puf_chal;
  logic [NP-1:0]   b_resp_bits, b_resp_unstable;

  apuf_eval_ctrl #(.CHAL_W(CW), .NUM_PUF(NP), .SETUP_CYC(SU), .SETTLE_CYC(ST), .REPEAT(RP)) u_dut_a (
    .clk(clk), .rst(rst), .chal_in(a_chal_in), .chal_valid(a_chal_valid), .chal_ready(a_chal_ready),
    .puf_chal(a_puf_chal), .puf_trig(a_puf_trig), .puf_resp(a_puf_resp), .resp_bits(a_resp_bits),
    .resp_out(a_resp_out), .resp_unstable(a_resp_unstable), .resp_valid(a_resp_valid),
    .resp_ready(a_resp_ready), .busy(a_busy)
  );

  apuf_eval_ctrl #(.CHAL_W(B_CW), .NUM_PUF(NP), .SETUP_CYC(B_SU), .SETTLE_CYC(B_ST), .REPEAT(B_RP)) u_dut_b (
    .clk(clk), .rst(rst), .chal_in(b_chal_in), .chal_valid(b_chal_valid), .chal_ready(b_chal_ready),
    .puf_chal(b_puf_chal), .puf_trig(b_puf_trig), .puf_resp(b_puf_resp), .resp_bits(b_resp_bits),
    .resp_out(b_resp_out), .resp_unstable(b_resp_unstable), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: nibble k of pat is the arbiter value seen during firing k.
  function automatic resp_t model(input logic [31:0] pat, input int n);
    resp_t r;
    int cnt;
    r = '0;
    for (int c = 0; c < NP; c++) begin
      cnt = 0;
      for (int k = 0; k < n; k++) cnt += int'(pat[4*k+c]);
      r.bits[c] = (cnt * 2 > n);
      r.unst[c] = (cnt != 0) && (cnt != n);
    end
    r.out = ^r.bits;
    return r;
  endfunction

  task automatic run_a(input logic [CW-1:0] chal, input logic [31:0] pat, input logic rdy,
                       output bit seen, output int lat, output int pulses, output int bad_len,
                       output bit chal_ok);
    bit prev;
    int plen, t0;
    seen = 0; lat = -1; pulses = 0; bad_len = 0; chal_ok = 1; prev = 0; plen = 0;
    a_resp_ready = rdy;
    @(negedge clk);
    a_chal_in = chal;
    a_chal_valid = 1'b1;
    sb_a.push_back(model(pat, RP));
    @(posedge clk); #1;
    t0 = cyc;
    a_chal_valid = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      if (a_puf_chal !== chal) chal_ok = 0;
      if (a_puf_trig === 1'b1) begin
        if (!prev) begin
          if (pulses < 8) a_puf_resp = pat[4*pulses +: 4];
          pulses++;
          plen = 0;
        end
        plen++;
      end else if (prev && plen != ST + 1) begin
        bad_len++;
      end
      prev = (a_puf_trig === 1'b1);
      if (a_resp_valid === 1'b1) begin
        seen = 1;
        lat = cyc - t0;
      end
    end
    if (rdy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_chal_ready, a_busy, a_puf_trig, a_resp_valid, a_resp_out} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 10000", {a_chal_ready, a_busy, a_puf_trig, a_resp_valid, a_resp_out});
    end
    checks++;
    if (a_puf_chal !== '0 || a_resp_bits !== '0 || a_resp_unstable !== '0) begin
      errors++; $display("FAIL reset_data: got chal=%0h bits=%b unst=%b expected zeros", a_puf_chal, a_resp_bits, a_resp_unstable);
    end
    checks++;
    if (b_chal_ready !== 1'b1 || b_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_b: got ready=%b valid=%b expected 1 0", b_chal_ready, b_resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    a_chal_in = 64'hDEAD_BEEF_0123_4567;
    a_chal_valid = 1'b1;
    a_puf_resp = 4'hF;
    @(posedge clk); #1;
    a_chal_valid = 1'b0;
    n = 0;
    while (a_puf_trig !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (a_puf_trig !== 1'b1) begin
      errors++; $display("FAIL reset_reach_fire: got trig=%b expected 1", a_puf_trig);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_puf_trig, a_resp_valid, a_chal_ready, a_busy} !== 4'b0010 || a_puf_chal !== '0) begin
      errors++; $display("FAIL reset_abort: got trig/valid/ready/busy=%b chal=%0h expected 0010 0",
                         {a_puf_trig, a_resp_valid, a_chal_ready, a_busy}, a_puf_chal);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_chal_ready !== 1'b1 || a_puf_trig !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b trig=%b expected 1 0", a_chal_ready, a_puf_trig);
    end
  endtask

  task automatic test_stable();
    bit seen, cok;
    int lat, pulses, bad;
    resp_t exp;
    run_a(64'hA5A5_0000_FFFF_1234, 32'hBBBB_BBBB, 1'b1, seen, lat, pulses, bad, cok);
    checks++;
    if (!seen || lat != 70) begin errors++; $display("FAIL stable_latency: got %0d expected 70", lat); end
    checks++;
    if (pulses != 5 || bad != 0) begin
      errors++; $display("FAIL stable_pulses: got %0d pulses %0d bad widths expected 5 pulses 0 bad", pulses, bad);
    end
    checks++;
    if (!cok) begin errors++; $display("FAIL stable_chal_hold: got changed expected A5A50000FFFF1234"); end
    checks++;
    if (sb_a.size() == 0) begin errors++; $display("FAIL stable_resp: got empty scoreboard expected entry"); end
    else begin
      exp = sb_a.pop_front();
      if ({a_resp_bits, a_resp_out, a_resp_unstable} !== exp) begin
        errors++; $display("FAIL stable_resp: got %0h expected %0h", {a_resp_bits, a_resp_out, a_resp_unstable}, exp);
      end
    end
    checks++;
    if (a_resp_valid !== 1'b0 || a_chal_ready !== 1'b1 || a_resp_bits !== 4'b1011) begin
      errors++; $display("FAIL stable_after_ack: got valid=%b ready=%b bits=%b expected 0 1 1011",
                         a_resp_valid, a_chal_ready, a_resp_bits);
    end
  endtask

  task automatic test_majority();
    bit seen, cok;
    int lat, pulses, bad;
    resp_t exp;
    logic [31:0] pats [3];
    pats[0] = 32'h0000_1101;
    pats[1] = 32'h0000_0100;
    pats[2] = 32'h0002_AEEA;
    for (int t = 0; t < 3; t++) begin
      run_a(64'h0F0F_1111_2222_0000 + 64'(t), pats[t], 1'b1, seen, lat, pulses, bad, cok);
      checks++;
      if (!seen || pulses != 5) begin
        errors++; $display("FAIL majority_run%0d: got seen=%0d pulses=%0d expected 1 5", t, seen, pulses);
      end
      checks++;
      if (sb_a.size() == 0) begin errors++; $display("FAIL majority_resp%0d: got empty scoreboard expected entry", t); end
      else begin
        exp = sb_a.pop_front();
        if ({a_resp_bits, a_resp_out, a_resp_unstable} !== exp) begin
          errors++; $display("FAIL majority_resp%0d: got %0h expected %0h", t, {a_resp_bits, a_resp_out, a_resp_unstable}, exp);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen, cok;
    int lat, pulses, bad;
    resp_t exp;
    logic [CW-1:0] chal;
    chal = 64'h0123_4567_89AB_CDEF;
    exp = '0;
    run_a(chal, 32'h000C_C4CC, 1'b0, seen, lat, pulses, bad, cok);
    checks++;
    if (!seen || lat != 70) begin errors++; $display("FAIL bp_latency: got %0d expected 70", lat); end
    checks++;
    if (sb_a.size() == 0) begin errors++; $display("FAIL bp_resp: got empty scoreboard expected entry"); end
    else begin
      exp = sb_a.pop_front();
      if ({a_resp_bits, a_resp_out, a_resp_unstable} !== exp) begin
        errors++; $display("FAIL bp_resp: got %0h expected %0h", {a_resp_bits, a_resp_out, a_resp_unstable}, exp);
      end
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      a_chal_valid = n[0];
      a_chal_in = ~chal;
      @(posedge clk); #1;
      checks++;
      if (a_resp_valid !== 1'b1 || a_chal_ready !== 1'b0 || a_puf_chal !== chal ||
          {a_resp_bits, a_resp_out, a_resp_unstable} !== exp) begin
        errors++; $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b resp=%0h expected 1 0 %0h",
                           n, a_resp_valid, a_chal_ready, {a_resp_bits, a_resp_out, a_resp_unstable}, exp);
      end
    end
    @(negedge clk);
    a_chal_valid = 1'b0;
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_resp_valid !== 1'b0 || a_chal_ready !== 1'b1 || a_puf_chal !== chal ||
        {a_resp_bits, a_resp_out, a_resp_unstable} !== exp) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b chal=%0h expected 0 1 %0h",
                         a_resp_valid, a_chal_ready, a_puf_chal, chal);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] c1, c2;
    resp_t exp;
    bit pv, hold_ok;
    int h, t2, nresp;
    c1 = 64'h1111_2222_3333_4444;
    c2 = 64'h5555_6666_7777_8888;
    h = -1; t2 = -1; nresp = 0; pv = 0; hold_ok = 1;
    a_resp_ready = 1'b1;
    a_puf_resp = 4'b0110;
    @(negedge clk);
    a_chal_in = c1;
    a_chal_valid = 1'b1;
    sb_a.push_back(model(32'h0006_6666, RP));
    sb_a.push_back(model(32'h0006_6666, RP));
    for (int n = 0; n < 400 && nresp < 2; n++) begin
      @(posedge clk); #1;
      if (pv && h < 0) h = cyc;
      if (a_busy === 1'b1 && a_puf_chal === c1) a_chal_in = c2;
      if (t2 < 0 && a_puf_chal === c2) begin
        t2 = cyc;
        a_chal_valid = 1'b0;
      end else if (t2 < 0 && a_busy === 1'b1 && a_puf_chal !== c1) begin
        hold_ok = 0;
      end
      if (a_resp_valid === 1'b1) begin
        nresp++;
        checks++;
        if (sb_a.size() == 0) begin errors++; $display("FAIL b2b_resp: got empty scoreboard expected entry"); end
        else begin
          exp = sb_a.pop_front();
          if ({a_resp_bits, a_resp_out, a_resp_unstable} !== exp) begin
            errors++; $display("FAIL b2b_resp%0d: got %0h expected %0h", nresp, {a_resp_bits, a_resp_out, a_resp_unstable}, exp);
          end
        end
      end
      pv = (a_resp_valid === 1'b1);
    end
    @(posedge clk); #1;
    checks++;
    if (nresp != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", nresp); end
    checks++;
    if (h < 0 || t2 - h != 1) begin
      errors++; $display("FAIL b2b_gap: got handshake %0d transfer %0d expected gap 1", h, t2);
    end
    checks++;
    if (!hold_ok) begin errors++; $display("FAIL b2b_chal_hold: got early change expected %0h", c1); end
  endtask

  task automatic test_corner();
    logic [7:0] pp;
    resp_t exp;
    int t0, lat, pulses, plen;
    bit seen, prev;
    pp = 8'h7A;
    for (int k = 0; k < 2; k++) begin
      seen = 0; lat = -1; pulses = 0; plen = 0; prev = 0;
      b_puf_resp = pp[4*k +: 4];
      @(negedge clk);
      b_chal_in = 16'h1234 + 16'(k);
      b_chal_valid = 1'b1;
      sb_b.push_back(model({28'h0, b_puf_resp}, B_RP));
      @(posedge clk); #1;
      t0 = cyc;
      b_chal_valid = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(posedge clk); #1;
        if (b_puf_trig === 1'b1) begin
          if (!prev) pulses++;
          plen++;
        end
        prev = (b_puf_trig === 1'b1);
        if (b_resp_valid === 1'b1) begin seen = 1; lat = cyc - t0; end
      end
      checks++;
      if (!seen || lat != 7) begin errors++; $display("FAIL corner_latency%0d: got %0d expected 7", k, lat); end
      checks++;
      if (pulses != 1 || plen != 4) begin
        errors++; $display("FAIL corner_pulse%0d: got %0d pulses width %0d expected 1 width 4", k, pulses, plen);
      end
      checks++;
      if (sb_b.size() == 0) begin errors++; $display("FAIL corner_resp%0d: got empty scoreboard expected entry", k); end
      else begin
        exp = sb_b.pop_front();
        if ({b_resp_bits, b_resp_out, b_resp_unstable} !== exp || b_resp_unstable !== 4'b0000) begin
          errors++; $display("FAIL corner_resp%0d: got %0h expected %0h", k, {b_resp_bits, b_resp_out, b_resp_unstable}, exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_majority();
    test_backpressure();
    test_back_to_back();
    test_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
